product_accumulator: RTL and testbench
======================================

# product_accumulator

Streaming accumulator directly downstream of the 16x16 `multiplier`. It consumes the 32-bit unsigned PRODUCT stream one term per accepted beat, sums the terms of a vector delimited by IN_LAST, and presents the dot-product result with a valid/ready handshake. It turns the combinational multiplier into a MAC datapath; one product accepted per cycle at most.

## Interface
- PROD_W, 32: product input width; matches the multiplier's PRODUCT width.
- ACC_W, 40: accumulator/result width (8 guard bits).
- LEN_W, 8: term-counter width.

- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- IN_VALID  in  1  PRODUCT/IN_LAST valid.
- IN_READY  out  1  block can accept a term.
- PRODUCT  in  PROD_W  unsigned product term.
- IN_LAST  in  1  final term of current vector.
- OUT_VALID  out  1  result held on ACC_OUT.
- OUT_READY  in  1  consumer accepts result.
- ACC_OUT  out  ACC_W  vector sum.
- OUT_COUNT  out  LEN_W  number of terms summed (saturating).
- OVERFLOW  out  1  sum exceeded ACC_W bits for this vector.

## Operation
- States: ACCUM (summing), HOLD (result presented).
- Accept = IN_VALID && IN_READY. IN_READY = (state == ACCUM).
- ACCUM, accept, !IN_LAST: acc <= acc + PRODUCT (zero-extended); cnt <= cnt+1 (saturating at 2^LEN_W-1); ovf |= carry out of ACC_W.
- ACCUM, accept, IN_LAST: ACC_OUT <= acc + PRODUCT; OUT_COUNT <= cnt+1 (saturating); OVERFLOW <= ovf | carry; clear acc/cnt/ovf; go to HOLD.
- HOLD: OUT_VALID=1; ACC_OUT, OUT_COUNT, OVERFLOW stable until OUT_VALID && OUT_READY, then go to ACCUM.
- Single-beat vector (IN_LAST on first term) is legal; OUT_COUNT=1.
- No accept, ACCUM: state unchanged.
- Arithmetic unsigned, modulo 2^ACC_W unless saturation is compiled in (see Configuration).
- Reset (RST_N low at an edge, any state): state=ACCUM, acc=0, cnt=0, ovf=0, OUT_VALID=0, ACC_OUT=0, OUT_COUNT=0, OVERFLOW=0. Partial vector or unconsumed result is discarded.

## Timing
- Reset values: IN_READY=1 (ACCUM), OUT_VALID=0, ACC_OUT=0, OUT_COUNT=0, OVERFLOW=0.
- Latency: last term accepted at edge N -> OUT_VALID=1 with result after edge N.
- IN_READY depends only on registered state; no combinational path from OUT_READY or IN_VALID to IN_READY.
- Output handshake completes at edge M -> IN_READY=1 after edge M; one-cycle bubble between vectors (max throughput: L terms per L+1 cycles when OUT_READY held high).
- IN_VALID asserted in HOLD: beat not accepted; upstream holds PRODUCT/IN_LAST stable until accepted.
- OUT_READY while OUT_VALID=0: ignored.

## Configuration
- PRODUCT_ACCUMULATOR_SAT_EN defined: on carry out of ACC_W, acc (and ACC_OUT) clamps to 2^ACC_W-1 and stays there for the rest of the vector; OVERFLOW still set.
- Not defined: sum wraps modulo 2^ACC_W; OVERFLOW set.

## Structure
- Package product_accumulator_pkg: state enum (ACCUM, HOLD), default PROD_W/ACC_W/LEN_W constants.
- One sub-module, acc_sat_adder: ACC_W adder returning sum and carry, with clamp under PRODUCT_ACCUMULATOR_SAT_EN. FSM and registers in top.

## Test plan
- Vector 45, 250, 510 (LAST on 510), OUT_READY=1 -> ACC_OUT=805, OUT_COUNT=3, OVERFLOW=0, OUT_VALID one cycle after last accept.
- Single term 4294836225 with IN_LAST -> ACC_OUT=4294836225, OUT_COUNT=1; IN_READY=0 during HOLD, high the cycle after the handshake.
- 257 terms of 4294967295 -> without SAT_EN ACC_OUT=4294967039, OVERFLOW=1, OUT_COUNT=255; with SAT_EN ACC_OUT=1099511627775, OVERFLOW=1.
- Result held with OUT_READY=0 for 5 cycles while IN_VALID=1 with term 80000 -> ACC_OUT stable, IN_READY=0, 80000 accepted only after handshake and forms the next vector's first term.
- Terms 16384, 16384 then RST_N low one cycle, then single term 10000 with LAST -> ACC_OUT=10000, OUT_COUNT=1; all outputs zero during reset.
- Back-to-back vectors {15,3 LAST} {25 LAST}, OUT_READY=1 -> results 18 then 25, one bubble cycle between.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator slice.
// PROD_W matches the multiplier product; ACC_W adds 8 guard bits.
package product_accumulator_pkg;

   localparam int PROD_W_DEF = 32;
   localparam int ACC_W_DEF  = 40;
   localparam int LEN_W_DEF  = 8;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

endpackage

// File: rtl/acc_sat_adder.sv
// ACC_W-bit unsigned adder reporting the carry out of the top bit.
// With PRODUCT_ACCUMULATOR_SAT_EN defined, the sum clamps to all-ones on carry.
module acc_sat_adder #(
   parameter int ACC_W = 40
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W:0] raw;

   assign raw   = {1'b0, a} + {1'b0, b};
   assign carry = raw[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
   // Once clamped, later terms keep carrying (or add zero), so the sum stays pinned.
   assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
   assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Streaming dot-product accumulator fed by the multiplier PRODUCT stream.
// Optional clamp-on-overflow is compiled in with PRODUCT_ACCUMULATOR_SAT_EN.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [PROD_W-1:0] PRODUCT,
   input  logic              IN_LAST,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [ACC_W-1:0]  ACC_OUT,
   output logic [LEN_W-1:0]  OUT_COUNT,
   output logic              OVERFLOW
);

   state_t             state;
   state_t             state_next;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   sum;
   logic               carry;
   logic [LEN_W-1:0]   cnt;
   logic [LEN_W-1:0]   cnt_inc;
   logic               ovf;
   logic               accept;

   // Both handshake flags come straight from the state register, no input feedthrough.
   assign IN_READY  = (state == ACCUM);
   assign OUT_VALID = (state == HOLD);
   assign accept    = IN_VALID && IN_READY;
   assign cnt_inc   = (cnt == {LEN_W{1'b1}}) ? cnt : cnt + LEN_W'(1);

   acc_sat_adder #(
      .ACC_W(ACC_W)
   ) u_adder (
      .a    (acc),
      .b    (ACC_W'(PRODUCT)),
      .sum  (sum),
      .carry(carry)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ACCUM:   if (accept && IN_LAST) state_next = HOLD;
         HOLD:    if (OUT_READY) state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // The final term goes straight into the result registers and restarts the running sum.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         ACC_OUT   <= '0;
         OUT_COUNT <= '0;
         OVERFLOW  <= 1'b0;
      end else if (accept) begin
         if (IN_LAST) begin
            ACC_OUT   <= sum;
            OUT_COUNT <= cnt_inc;
            OVERFLOW  <= ovf | carry;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
         end else begin
            acc <= sum;
            cnt <= cnt_inc;
            ovf <= ovf | carry;
         end
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator using an expected-result queue.
// Expectations follow PRODUCT_ACCUMULATOR_SAT_EN when the design is built with it.
module tb_product_accumulator;

   typedef struct {
      logic [39:0] acc;
      logic [7:0]  cnt;
      logic        ovf;
   } exp_t;

   logic        CLK;
   logic        RST_N;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] PRODUCT;
   logic        IN_LAST;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [39:0] ACC_OUT;
   logic [7:0]  OUT_COUNT;
   logic        OVERFLOW;

   int   checks;
   int   failures;
   exp_t exp_q[$];

   product_accumulator dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .PRODUCT  (PRODUCT),
      .IN_LAST  (IN_LAST),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .ACC_OUT  (ACC_OUT),
      .OUT_COUNT(OUT_COUNT),
      .OVERFLOW (OVERFLOW)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive one beat and wait (bounded) until it is accepted; cycles counts edges spent.
   task automatic send_term(input logic [31:0] p, input logic l, output int cycles);
      logic rdy;
      bit   accepted;
      accepted = 0;
      cycles   = 0;
      IN_VALID = 1'b1;
      PRODUCT  = p;
      IN_LAST  = l;
      while (!accepted && cycles < 1000) begin
         rdy = IN_READY;
         @(posedge CLK);
         #1;
         cycles++;
         if (rdy) accepted = 1;
      end
      IN_VALID = 1'b0;
      IN_LAST  = 1'b0;
      if (!accepted) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout term=%0d got=not_accepted want=accepted", p);
      end
   endtask

   task automatic handshake();
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      IN_VALID  = 1'b0;
      PRODUCT   = '0;
      IN_LAST   = 1'b0;
      OUT_READY = 1'b0;
      RST_N     = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", IN_READY); end
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", OUT_VALID); end
      checks++; if (ACC_OUT !== 40'd0) begin failures++; $display("[TB] FAIL reset_acc got=%0d want=0", ACC_OUT); end
      checks++; if (OUT_COUNT !== 8'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d want=0", OUT_COUNT); end
      checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b want=0", OVERFLOW); end
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_basic();
      int   cyc;
      exp_t e;
      OUT_READY = 1'b1;
      exp_q.push_back('{acc: 40'd805, cnt: 8'd3, ovf: 1'b0});
      send_term(32'd45, 1'b0, cyc);
      send_term(32'd250, 1'b0, cyc);
      send_term(32'd510, 1'b1, cyc);
      checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("[TB] FAIL basic_latency got=%b want=1", OUT_VALID); end
      e = exp_q.pop_front();
      checks++; if (ACC_OUT !== e.acc) begin failures++; $display("[TB] FAIL basic_acc got=%0d want=%0d", ACC_OUT, e.acc); end
      checks++; if (OUT_COUNT !== e.cnt) begin failures++; $display("[TB] FAIL basic_count got=%0d want=%0d", OUT_COUNT, e.cnt); end
      checks++; if (OVERFLOW !== e.ovf) begin failures++; $display("[TB] FAIL basic_ovf got=%b want=%b", OVERFLOW, e.ovf); end
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL basic_drain got=%b want=0", OUT_VALID); end
   endtask

   task automatic test_single();
      int   cyc;
      exp_t e;
      OUT_READY = 1'b0;
      exp_q.push_back('{acc: 40'd4294836225, cnt: 8'd1, ovf: 1'b0});
      send_term(32'd4294836225, 1'b1, cyc);
      e = exp_q.pop_front();
      checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b want=1", OUT_VALID); end
      checks++; if (IN_READY !== 1'b0) begin failures++; $display("[TB] FAIL single_ready_hold got=%b want=0", IN_READY); end
      checks++; if (ACC_OUT !== e.acc) begin failures++; $display("[TB] FAIL single_acc got=%0d want=%0d", ACC_OUT, e.acc); end
      checks++; if (OUT_COUNT !== e.cnt) begin failures++; $display("[TB] FAIL single_count got=%0d want=%0d", OUT_COUNT, e.cnt); end
      handshake();
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL single_ready_after got=%b want=1", IN_READY); end
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_after got=%b want=0", OUT_VALID); end
   endtask

   task automatic test_overflow();
      int   cyc;
      exp_t e;
      OUT_READY = 1'b0;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
      exp_q.push_back('{acc: 40'd1099511627775, cnt: 8'd255, ovf: 1'b1});
`else
      exp_q.push_back('{acc: 40'd4294967039, cnt: 8'd255, ovf: 1'b1});
`endif
      for (int i = 0; i < 256; i++) send_term(32'hFFFF_FFFF, 1'b0, cyc);
      send_term(32'hFFFF_FFFF, 1'b1, cyc);
      e = exp_q.pop_front();
      checks++; if (ACC_OUT !== e.acc) begin failures++; $display("[TB] FAIL ovf_acc got=%0d want=%0d", ACC_OUT, e.acc); end
      checks++; if (OUT_COUNT !== e.cnt) begin failures++; $display("[TB] FAIL ovf_count got=%0d want=%0d", OUT_COUNT, e.cnt); end
      checks++; if (OVERFLOW !== e.ovf) begin failures++; $display("[TB] FAIL ovf_flag got=%b want=%b", OVERFLOW, e.ovf); end
      handshake();
   endtask

   task automatic test_hold();
      int   cyc;
      exp_t e;
      OUT_READY = 1'b0;
      exp_q.push_back('{acc: 40'd300, cnt: 8'd2, ovf: 1'b0});
      send_term(32'd100, 1'b0, cyc);
      send_term(32'd200, 1'b1, cyc);
      e = exp_q.pop_front();
      exp_q.push_back('{acc: 40'd80000, cnt: 8'd1, ovf: 1'b0});
      IN_VALID = 1'b1;
      PRODUCT  = 32'd80000;
      IN_LAST  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (ACC_OUT !== e.acc) begin failures++; $display("[TB] FAIL hold_acc cyc=%0d got=%0d want=%0d", i, ACC_OUT, e.acc); end
         checks++; if (IN_READY !== 1'b0) begin failures++; $display("[TB] FAIL hold_ready cyc=%0d got=%b want=0", i, IN_READY); end
         @(posedge CLK);
         #1;
      end
      checks++; if (OUT_COUNT !== e.cnt) begin failures++; $display("[TB] FAIL hold_count got=%0d want=%0d", OUT_COUNT, e.cnt); end
      handshake();
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL hold_ready_after got=%b want=1", IN_READY); end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      IN_LAST  = 1'b0;
      e = exp_q.pop_front();
      checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("[TB] FAIL hold_next_valid got=%b want=1", OUT_VALID); end
      checks++; if (ACC_OUT !== e.acc) begin failures++; $display("[TB] FAIL hold_next_acc got=%0d want=%0d", ACC_OUT, e.acc); end
      checks++; if (OUT_COUNT !== e.cnt) begin failures++; $display("[TB] FAIL hold_next_count got=%0d want=%0d", OUT_COUNT, e.cnt); end
      handshake();
   endtask

   task automatic test_reset_mid();
      int   cyc;
      exp_t e;
      OUT_READY = 1'b0;
      send_term(32'd16384, 1'b0, cyc);
      send_term(32'd16384, 1'b0, cyc);
      RST_N = 1'b0;
      @(posedge CLK);
      #1;
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_ready got=%b want=1", IN_READY); end
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b want=0", OUT_VALID); end
      checks++; if (ACC_OUT !== 40'd0) begin failures++; $display("[TB] FAIL rstmid_acc got=%0d want=0", ACC_OUT); end
      checks++; if (OUT_COUNT !== 8'd0) begin failures++; $display("[TB] FAIL rstmid_count got=%0d want=0", OUT_COUNT); end
      checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ovf got=%b want=0", OVERFLOW); end
      RST_N = 1'b1;
      exp_q.push_back('{acc: 40'd10000, cnt: 8'd1, ovf: 1'b0});
      send_term(32'd10000, 1'b1, cyc);
      e = exp_q.pop_front();
      checks++; if (ACC_OUT !== e.acc) begin failures++; $display("[TB] FAIL rstmid_new_acc got=%0d want=%0d", ACC_OUT, e.acc); end
      checks++; if (OUT_COUNT !== e.cnt) begin failures++; $display("[TB] FAIL rstmid_new_count got=%0d want=%0d", OUT_COUNT, e.cnt); end
      handshake();
   endtask

   task automatic test_back_to_back();
      int   cyc;
      exp_t e;
      OUT_READY = 1'b1;
      exp_q.push_back('{acc: 40'd18, cnt: 8'd2, ovf: 1'b0});
      exp_q.push_back('{acc: 40'd25, cnt: 8'd1, ovf: 1'b0});
      send_term(32'd15, 1'b0, cyc);
      send_term(32'd3, 1'b1, cyc);
      e = exp_q.pop_front();
      checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_valid got=%b want=1", OUT_VALID); end
      checks++; if (ACC_OUT !== e.acc) begin failures++; $display("[TB] FAIL b2b_first_acc got=%0d want=%0d", ACC_OUT, e.acc); end
      checks++; if (OUT_COUNT !== e.cnt) begin failures++; $display("[TB] FAIL b2b_first_count got=%0d want=%0d", OUT_COUNT, e.cnt); end
      send_term(32'd25, 1'b1, cyc);
      checks++; if (cyc !== 2) begin failures++; $display("[TB] FAIL b2b_bubble got=%0d want=2", cyc); end
      e = exp_q.pop_front();
      checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_valid got=%b want=1", OUT_VALID); end
      checks++; if (ACC_OUT !== e.acc) begin failures++; $display("[TB] FAIL b2b_second_acc got=%0d want=%0d", ACC_OUT, e.acc); end
      checks++; if (OUT_COUNT !== e.cnt) begin failures++; $display("[TB] FAIL b2b_second_count got=%0d want=%0d", OUT_COUNT, e.cnt); end
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got=%b want=0", OUT_VALID); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_single();
      test_overflow();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
